// File: rtl/kalman_meas_scheduler_if.sv
// rtl/kalman_meas_scheduler_if.sv - ADC, register-file and filter-core signals of kalman_meas_scheduler
interface kalman_meas_scheduler_if #(
    parameter int MEAS_W    = 14,
    parameter int OVR_CNT_W = 16
);
    logic signed [MEAS_W-1:0]    i_adc_data;
    logic                        i_adc_valid;
    logic [3:0]                  i_dec_log2;
    logic [31:0]                 i_kal_Q;
    logic [31:0]                 i_kal_R;
    logic                        i_cfg_wr;
    logic                        i_kal_done;
    logic signed [MEAS_W-1:0]    o_kal_meas;
    logic [31:0]                 o_kal_Q;
    logic [31:0]                 o_kal_R;
    logic                        o_kal_start;
    logic                        o_busy;
    logic [31:0]                 o_update_cnt;
    logic [OVR_CNT_W-1:0]        o_overrun_cnt;
    logic                        o_wdt_flag;

    modport master (
        output i_adc_data, i_adc_valid, i_dec_log2, i_kal_Q, i_kal_R, i_cfg_wr, i_kal_done,
        input  o_kal_meas, o_kal_Q, o_kal_R, o_kal_start, o_busy, o_update_cnt,
               o_overrun_cnt, o_wdt_flag
    );

    modport slave (
        input  i_adc_data, i_adc_valid, i_dec_log2, i_kal_Q, i_kal_R, i_cfg_wr, i_kal_done,
        output o_kal_meas, o_kal_Q, o_kal_R, o_kal_start, o_busy, o_update_cnt,
               o_overrun_cnt, o_wdt_flag
    );
endinterface

// File: rtl/kalman_meas_scheduler.sv
// rtl/kalman_meas_scheduler.sv - ADC decimator and Kalman update launcher; KAL_SCHED_WDT_EN adds a WAIT watchdog
module kalman_meas_scheduler #(
    parameter int          MEAS_W       = 14,
    parameter int          MAX_DEC_LOG2 = 8,
    parameter logic [31:0] Q_RST        = 32'd5,
    parameter logic [31:0] R_RST        = 32'd10,
    parameter int          OVR_CNT_W    = 16,
    parameter int          WDT_CYCLES   = 4096
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    kalman_meas_scheduler_if.slave   bus
);
    localparam int         ACC_W = MEAS_W + MAX_DEC_LOG2;
    localparam int         CNT_W = MAX_DEC_LOG2 + 1;
    localparam logic [3:0] MAX_N = 4'(MAX_DEC_LOG2);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [1:0]               state;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_nxt;
    logic [3:0]               n_lat;
    logic [3:0]               n_req;
    logic [3:0]               n_cur;
    logic                     win_done;
    logic signed [MEAS_W-1:0] avg;
    logic signed [MEAS_W-1:0] pend_data;
    logic                     pend_vld;
    logic                     take;
    logic [31:0]              stage_q;
    logic [31:0]              stage_r;
    logic                     cfg_pend;
    logic signed [MEAS_W-1:0] meas;
    logic [31:0]              kal_q;
    logic [31:0]              kal_r;
    logic                     start;
    logic [31:0]              upd_cnt;
    logic [OVR_CNT_W-1:0]     ovr_cnt;

    // The window exponent is sampled only on the first sample of a window.
    always_comb begin
        n_req    = (bus.i_dec_log2 > MAX_N) ? MAX_N : bus.i_dec_log2;
        n_cur    = (cnt == '0) ? n_req : n_lat;
        acc_sum  = acc + {{MAX_DEC_LOG2{bus.i_adc_data[MEAS_W-1]}}, bus.i_adc_data};
        cnt_nxt  = cnt + 1'b1;
        win_done = bus.i_adc_valid && (cnt_nxt == (CNT_W'(1) << n_cur));
        avg      = MEAS_W'(acc_sum >>> n_cur);
        take     = (state == S_IDLE) && pend_vld;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            n_lat <= '0;
        end else if (bus.i_adc_valid) begin
            if (cnt == '0)
                n_lat <= n_req;
            if (win_done) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc_sum;
                cnt <= cnt_nxt;
            end
        end
    end

    // A window landing in the launch cycle refills the slot without counting as an overrun.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_data <= '0;
            pend_vld  <= 1'b0;
            ovr_cnt   <= '0;
        end else if (win_done) begin
            pend_data <= avg;
            pend_vld  <= 1'b1;
            if (pend_vld && !take && (ovr_cnt != '1))
                ovr_cnt <= ovr_cnt + 1'b1;
        end else if (take) begin
            pend_vld <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage_q  <= '0;
            stage_r  <= '0;
            cfg_pend <= 1'b0;
        end else if (bus.i_cfg_wr) begin
            stage_q  <= bus.i_kal_Q;
            stage_r  <= bus.i_kal_R;
            cfg_pend <= 1'b1;
        end else if (take) begin
            cfg_pend <= 1'b0;
        end
    end

`ifdef KAL_SCHED_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] wdt_cnt;
    logic             wdt_flag;
`endif

    // Measurement and coefficients are registered on the take edge so they are valid alongside start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            start   <= 1'b0;
            meas    <= '0;
            kal_q   <= Q_RST;
            kal_r   <= R_RST;
            upd_cnt <= '0;
`ifdef KAL_SCHED_WDT_EN
            wdt_cnt  <= '0;
            wdt_flag <= 1'b0;
`endif
        end else begin
            start <= take;
            case (state)
                S_IDLE: begin
                    if (pend_vld) begin
                        state <= S_LAUNCH;
                        meas  <= pend_data;
                        if (cfg_pend) begin
                            kal_q <= stage_q;
                            kal_r <= stage_r;
                        end
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
`ifdef KAL_SCHED_WDT_EN
                    wdt_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (bus.i_kal_done) begin
                        state   <= S_IDLE;
                        upd_cnt <= upd_cnt + 32'd1;
                    end
`ifdef KAL_SCHED_WDT_EN
                    else if (wdt_cnt == WDT_W'(WDT_CYCLES - 1)) begin
                        state    <= S_IDLE;
                        wdt_flag <= 1'b1;
                    end else begin
                        wdt_cnt <= wdt_cnt + 1'b1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef KAL_SCHED_WDT_EN
    assign bus.o_wdt_flag = wdt_flag;
`else
    // Constant 0: no watchdog in this build.
    assign bus.o_wdt_flag = (WDT_CYCLES < 0);
`endif

    assign bus.o_kal_meas    = meas;
    assign bus.o_kal_Q       = kal_q;
    assign bus.o_kal_R       = kal_r;
    assign bus.o_kal_start   = start;
    assign bus.o_busy        = (state != S_IDLE);
    assign bus.o_update_cnt  = upd_cnt;
    assign bus.o_overrun_cnt = ovr_cnt;
endmodule
